// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
//   Shared definitions for the serializer and its front-end arbiter:
//   sample width, default channel count, header/footer byte values and the
//   arbiter frame-sequencing state encoding.
// ---------------------------------------------------------------------------
package serializer_pkg;

    localparam int SAMPLE_W         = 8;
    localparam int NUM_CHANNELS_DEF = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Bytes the serializer frames each data burst with.
    localparam sample_t HEADER = 8'hAA;
    localparam sample_t FOOTER = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_HDR   = 3'd2,
        ST_DATA  = 3'd3,
        ST_FTR   = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

endpackage

// File: rtl/serializer_arbiter_if.sv
// ---------------------------------------------------------------------------
// serializer_arbiter_if
//   Bundles the source-side and serializer-side signals of the arbiter.
//   master : the environment (sources, enable) -- drives requests and data
//   slave  : the arbiter -- drives read strobes, grants and serializer inputs
//
//   enable        1 = new frames may be granted
//   src_req       per-source request (source holds a full frame)
//   src_data      flattened current word, source i on [8i+7:8i]
//   src_rd        per-source read strobe, source advances on clk when high
//   src_grant     one-hot grant held for the whole frame
//   ser_din       sample to the serializer
//   ser_din_valid frame start pulse to the serializer
//   busy          arbiter not idle
//   frame_done    one-cycle pulse in the footer cycle
//   frame_src     index of the current/last granted source
// ---------------------------------------------------------------------------
interface serializer_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
);
    import serializer_pkg::*;

    logic                        enable;
    logic [NUM_SRC-1:0]          src_req;
    logic [NUM_SRC*SAMPLE_W-1:0] src_data;
    logic [NUM_SRC-1:0]          src_rd;
    logic [NUM_SRC-1:0]          src_grant;
    sample_t                     ser_din;
    logic                        ser_din_valid;
    logic                        busy;
    logic                        frame_done;
    logic [SRC_W-1:0]            frame_src;

    modport master (
        output enable, src_req, src_data,
        input  src_rd, src_grant, ser_din, ser_din_valid, busy, frame_done, frame_src
    );

    modport slave (
        input  enable, src_req, src_data,
        output src_rd, src_grant, ser_din, ser_din_valid, busy, frame_done, frame_src
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Scans req starting at index
//   'start' and wrapping modulo NUM_SRC; the first set bit wins.
//
//   req       in  NUM_SRC  request vector
//   start     in  SRC_W    first index to examine
//   grant     out NUM_SRC  one-hot winner (all zero when req == 0)
//   grant_idx out SRC_W    binary index of the winner (0 when req == 0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   start,
    output logic [NUM_SRC-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx
);

    int               pos;
    logic [SRC_W-1:0] idx;
    logic             found;

    always_comb begin
        // NOTE: every signal written here gets a default before the loop, so
        // no path through the block leaves it unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = int'(start) + k;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            idx = SRC_W'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// ---------------------------------------------------------------------------
// serializer_arbiter
//   Shares one serializer among NUM_SRC frame sources. In IDLE it picks a
//   requester round-robin, pulses ser_din_valid for one cycle, waits out the
//   serializer's header cycle, streams NUM_CHANNELS words from the granted
//   source (one read strobe per word), idles through the footer cycle and
//   GAP_CYCLES further cycles, then arbitrates again.
//
//   clk  in  clock shared with the serializer
//   rst  in  synchronous, active-high reset shared with the serializer
//   bus  slave modport of serializer_arbiter_if (see interface header)
//
//   All outputs decode from registered state/grant/counter; src_req only
//   feeds the next-state logic. ser_din muxes src_data combinationally so
//   the word tracks the source as it advances on each read strobe.
// ---------------------------------------------------------------------------
module serializer_arbiter
    import serializer_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int GAP_CYCLES   = 1,
    parameter int SRC_W        = $clog2(NUM_SRC)
) (
    input logic                 clk,
    input logic                 rst,
    serializer_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_CHANNELS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [SRC_W-1:0]   src_q, src_d;
    // rr_q is where the next search begins: one past the last winner.
    logic [SRC_W-1:0]   rr_q, rr_d;

    logic [NUM_SRC-1:0] arb_grant;
    logic [SRC_W-1:0]   arb_idx;
    sample_t            mux_word;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .req       (bus.src_req),
        .start     (rr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from the values
        // present before the edge, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        grant_d = grant_q;
        src_d   = src_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable && (|bus.src_req)) begin
                    grant_d = arb_grant;
                    src_d   = arb_idx;
                    rr_d    = (int'(arb_idx) == NUM_SRC - 1) ? '0 : arb_idx + SRC_W'(1);
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_HDR;
            ST_HDR: begin
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (int'(cnt_q) == NUM_CHANNELS - 1) begin
                    cnt_d   = '0;
                    state_d = ST_FTR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FTR: begin
                if (GAP_CYCLES > 0) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (int'(gap_q) == GAP_CYCLES - 1) begin
                    gap_d   = '0;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gap_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    // grant_q is one-hot, so an OR of masked words selects the granted source.
    always_comb begin
        mux_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                mux_word = mux_word | bus.src_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        bus.src_grant     = grant_q;
        bus.frame_src     = src_q;
        bus.busy          = (state_q != ST_IDLE);
        bus.ser_din_valid = (state_q == ST_START);
        bus.frame_done    = (state_q == ST_FTR);
        bus.src_rd        = '0;
        bus.ser_din       = '0;
        if (state_q == ST_DATA) begin
            bus.src_rd  = grant_q;
            bus.ser_din = mux_word;
        end
    end

endmodule

// File: tb/tb_serializer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serializer_arbiter
//   Drives serializer_arbiter through its interface. Each source is an
//   endless word counter (source i emits i*64 + words_read). A frame-position
//   reference model predicts every output each cycle; a small serializer
//   model rebuilds the header/data/footer stream. A vector table covers the
//   reset and arbitration corner cases; hand sequences and random traffic
//   cover the rest.
// ---------------------------------------------------------------------------
module tb_serializer_arbiter;
    import serializer_pkg::*;

    localparam int NS         = 4;
    localparam int NCH        = 16;
    localparam int GAP        = 1;
    localparam int SW         = 2;
    localparam int FRAME_BUSY = 3 + NCH + GAP;   // START, HDR, DATA.., FTR, GAP..
    localparam int PERIOD     = FRAME_BUSY + 1;  // plus the IDLE arbitration cycle

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serializer_arbiter_if #(.NUM_SRC(NS), .SRC_W(SW)) bus ();

    serializer_arbiter #(
        .NUM_SRC      (NS),
        .NUM_CHANNELS (NCH),
        .GAP_CYCLES   (GAP),
        .SRC_W        (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [NS-1:0] grant;
        logic [NS-1:0] rd;
        logic [7:0]    din;
        logic          valid;
        logic          busy;
        logic          done;
        logic [SW-1:0] src;
    } out_t;

    typedef struct {
        logic          r;
        logic          e;
        logic [NS-1:0] q;
        logic [NS-1:0] grant;
        logic [NS-1:0] rd;
        logic          valid;
        logic          busy;
        logic [SW-1:0] src;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;

    // reference model: frame position instead of a state machine
    bit m_busy;
    int m_pos, m_src, m_last, m_next;
    int m_rdcnt [NS];
    // stimulus sources
    int s_cnt [NS];
    // observations
    int rd_obs [NS];
    int done_cnt, multi_cnt;
    int valid_t [$];
    int valid_src [$];
    logic [7:0] dout_q [$];
    int sp = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NS; i++) bus.src_data[i*8 +: 8] = 8'(i * 64 + s_cnt[i]);
    endtask

    function automatic out_t get_out();
        out_t o;
        o.grant = bus.src_grant;
        o.rd    = bus.src_rd;
        o.din   = bus.ser_din;
        o.valid = bus.ser_din_valid;
        o.busy  = bus.busy;
        o.done  = bus.frame_done;
        o.src   = bus.frame_src;
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o = '0;
        o.src = SW'(m_last);
        if (m_busy) begin
            o.busy  = 1'b1;
            o.grant = NS'(1) << m_src;
            o.valid = (m_pos == 0);
            o.done  = (m_pos == 2 + NCH);
            if (m_pos >= 2 && m_pos < 2 + NCH) begin
                o.rd  = NS'(1) << m_src;
                o.din = 8'(m_src * 64 + m_rdcnt[m_src]);
            end
        end
        return o;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [NS-1:0] q);
        // a read strobe at this edge consumes a word even if reset is asserted
        if (m_busy && m_pos >= 2 && m_pos < 2 + NCH) m_rdcnt[m_src]++;
        if (r) begin
            m_busy = 0; m_pos = 0; m_last = 0; m_next = 0;
        end else if (!m_busy) begin
            if (e && q != '0) begin
                for (int k = NS - 1; k >= 0; k--)
                    if (q[(m_next + k) % NS]) m_src = (m_next + k) % NS;
                m_last = m_src;
                m_next = (m_src + 1) % NS;
                m_busy = 1;
                m_pos  = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME_BUSY) begin
                m_busy = 0;
                m_pos  = 0;
            end
        end
    endtask

    // One clock: apply inputs, edge, advance sources and model, compare.
    task automatic cyc(input logic r, input logic e, input logic [NS-1:0] q);
        logic [NS-1:0] rd_now;
        rd_now = bus.src_rd;
        rst = r;
        bus.enable = e;
        bus.src_req = q;
        @(posedge clk);
        model_step(r, e, q);
        #1;
        for (int i = 0; i < NS; i++) if (rd_now[i] === 1'b1) s_cnt[i]++;
        drive_src();
        @(negedge clk);
        cycle++;
        check($sformatf("cycle%0d", cycle), 32'(get_out()), 32'(model_out()));
        for (int i = 0; i < NS; i++) if (bus.src_rd[i] === 1'b1) rd_obs[i]++;
        if (bus.frame_done === 1'b1) done_cnt++;
        if (!$onehot0(bus.src_grant)) multi_cnt++;
        if (bus.ser_din_valid === 1'b1) begin
            valid_t.push_back(cycle);
            valid_src.push_back(int'(bus.frame_src));
        end
        // serializer: header after valid, NCH data words, then footer
        if (r) sp = -1;
        if (sp >= 0) begin
            if (sp == 0)        dout_q.push_back(HEADER);
            else if (sp <= NCH) dout_q.push_back(bus.ser_din);
            else                dout_q.push_back(FOOTER);
            sp = (sp == NCH + 1) ? -1 : sp + 1;
        end
        if (sp < 0 && bus.ser_din_valid === 1'b1 && !r) sp = 0;
    endtask

    task automatic run(input int n, input logic e, input logic [NS-1:0] q);
        repeat (n) cyc(1'b0, e, q);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NS; i++) rd_obs[i] = 0;
        done_cnt = 0;
        multi_cnt = 0;
        valid_t.delete();
        valid_src.delete();
        dout_q.delete();
    endtask

    task automatic check_starts(input string name, input int n, input int src, input bit fixed);
        check({name, "_frames"}, 32'(valid_t.size()), 32'(n));
        for (int i = 0; i < valid_t.size(); i++) begin
            check($sformatf("%s_src%0d", name, i), 32'(valid_src[i]), 32'(fixed ? src : i % NS));
            if (i > 0) check($sformatf("%s_gap%0d", name, i), 32'(valid_t[i] - valid_t[i-1]), 32'(PERIOD));
        end
    endtask

    vec_t vt [12];

    initial begin
        logic [7:0] exp8;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.src_req = '0;
        drive_src();

        // ---- vector table: reset, enable gating, pointer start, req drop ----
        //          r     e     req       grant    rd       val   busy  src
        vt[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[1]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[3]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2};
        vt[4]  = '{1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2};
        vt[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2};
        vt[6]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[7]  = '{1'b0, 1'b1, 4'b1010, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1};
        vt[8]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[9]  = '{1'b0, 1'b1, 4'b1001, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0};
        vt[10] = '{1'b0, 1'b1, 4'b1001, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0};
        vt[11] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].r, vt[i].e, vt[i].q);
            check($sformatf("vec%0d", i),
                  32'({bus.src_grant, bus.src_rd, bus.ser_din_valid, bus.busy, bus.frame_src}),
                  32'({vt[i].grant, vt[i].rd, vt[i].valid, vt[i].busy, vt[i].src}));
        end

        // ---- 1: single frame from source 0, serializer stream AA 00..0F FF ----
        cyc(1'b1, 1'b0, '0);
        clear_obs();
        run(PERIOD, 1'b1, 4'b0001);
        run(3, 1'b1, 4'b0000);
        check("t1_len", 32'(dout_q.size()), 32'(NCH + 2));
        for (int i = 0; i < NCH + 2 && i < dout_q.size(); i++) begin
            exp8 = (i == 0) ? HEADER : (i == NCH + 1) ? FOOTER : 8'(i - 1);
            check($sformatf("t1_dout%0d", i), 32'(dout_q[i]), 32'(exp8));
        end
        check("t1_rd0", 32'(rd_obs[0]), 32'(NCH));
        check("t1_valid", 32'(valid_t.size()), 32'd1);

        // ---- 2: all requesting -> 0,1,2,3,0 spaced one frame period ----
        cyc(1'b1, 1'b0, '0);
        clear_obs();
        run(5 * PERIOD, 1'b1, 4'b1111);
        run(PERIOD + 1, 1'b1, 4'b0000);
        check_starts("t2", 5, 0, 1'b0);

        // ---- 3: one-cycle request pulse from source 2 ----
        clear_obs();
        cyc(1'b0, 1'b1, 4'b0100);
        run(PERIOD + 2, 1'b1, 4'b0000);
        check_starts("t3", 1, 2, 1'b1);
        check("t3_rd2", 32'(rd_obs[2]), 32'(NCH));
        check("t3_rd_other", 32'(rd_obs[0] + rd_obs[1] + rd_obs[3]), 32'd0);
        check("t3_done", 32'(done_cnt), 32'd1);

        // ---- 4: enable dropped at the 5th DATA cycle ----
        clear_obs();
        run(6, 1'b1, 4'b1111);
        run(40, 1'b0, 4'b1111);
        check("t4_valid", 32'(valid_t.size()), 32'd1);
        check("t4_rd", 32'(rd_obs[0] + rd_obs[1] + rd_obs[2] + rd_obs[3]), 32'(NCH));
        check("t4_done", 32'(done_cnt), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        run(PERIOD, 1'b1, 4'b1111);

        // ---- 5: reset at DATA counter 7, then clean frame from source 1 ----
        cyc(1'b1, 1'b0, '0);
        clear_obs();
        run(10, 1'b1, 4'b0001);
        check("t5_pre_rd", 32'(rd_obs[0]), 32'd8);
        cyc(1'b1, 1'b1, 4'b0001);
        check("t5_rst_outs", 32'(get_out()), 32'd0);
        clear_obs();
        run(PERIOD, 1'b1, 4'b0010);
        run(PERIOD, 1'b1, 4'b0000);
        check_starts("t5", 1, 1, 1'b1);
        check("t5_rd1", 32'(rd_obs[1]), 32'(NCH));
        check("t5_rd0", 32'(rd_obs[0]), 32'd0);

        // ---- 6: source 3 alone, back-to-back frames ----
        cyc(1'b1, 1'b0, '0);
        clear_obs();
        run(3 * PERIOD, 1'b1, 4'b1000);
        run(PERIOD, 1'b1, 4'b0000);
        check_starts("t6", 3, 3, 1'b1);
        check("t6_multi_grant", 32'(multi_cnt), 32'd0);

        // ---- random traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            logic          r;
            logic          e;
            logic [NS-1:0] q;
            r = ($urandom_range(0, 399) == 0);
            e = ($urandom_range(0, 7) != 0);
            q = ($urandom_range(0, 2) == 0) ? '0 : NS'($urandom);
            cyc(r, e, q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
Shares one serializer among NUM_SRC readout sources, each holding a complete frame of NUM_CHANNELS 8-bit samples. Picks a requester round-robin and pulses the serializer's din_valid. It then streams the granted source's samples on ser_din in lockstep with the serializer's header/data/footer timing, and enforces a minimum inter-frame gap. Sits between the per-board channel buffers and the serializer; shares clk/rst with the serializer.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
NUM_CHANNELS, 16, samples per frame; must equal the serializer's channel count
GAP_CYCLES, 1, idle cycles inserted after the footer cycle before next arbitration (0..15)
SRC_W, 2, width of source index, = $clog2(NUM_SRC)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = arbitration allowed; 0 blocks new frames only
src_req  in  NUM_SRC  per-source request; high only when source holds >= NUM_CHANNELS words
src_data  in  NUM_SRC*8  flattened per-source current word; source i uses bits [8i+7:8i]
src_rd  out  NUM_SRC  per-source read strobe; source advances to next word on clk when high
src_grant  out  NUM_SRC  one-hot grant, held for the whole frame
ser_din  out  8  sample to the serializer din
ser_din_valid  out  1  frame start pulse to the serializer din_valid
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse in the footer cycle
frame_src  out  SRC_W  index of the current/last granted source

Behaviour:
- Reset: state IDLE, src_grant=0, src_rd=0, ser_din=0, ser_din_valid=0, busy=0, frame_done=0, frame_src=0, rr pointer=0, counters=0.
- All outputs decode from registered state, grant and counter only. No combinational path from src_req to any output.
- States: IDLE, START, HDR, DATA, FTR, GAP.
- IDLE: if enable and |src_req, pick a winner round-robin. Search starts at (last winner+1) mod NUM_SRC. Register the one-hot grant and frame_src, update the rr pointer to the winner, go to START.
- START, 1 cycle: ser_din_valid=1. The serializer sees valid in its IDLE and enters its header state next cycle.
- HDR, 1 cycle: serializer emits header; ser_din=0.
- DATA, NUM_CHANNELS cycles, counter 0..NUM_CHANNELS-1:
  - ser_din = src_data word of the granted source.
  - src_rd[granted]=1 each cycle.
  - Exit to FTR when counter==NUM_CHANNELS-1.
  - Exactly NUM_CHANNELS read strobes per frame.
- FTR, 1 cycle: frame_done=1, ser_din=0. Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP, GAP_CYCLES cycles: then IDLE; src_grant cleared on entering IDLE.
- Frame period: 1 (IDLE) + 1 + 1 + NUM_CHANNELS + 1 + GAP_CYCLES = 21 cycles at defaults (1 IDLE arbitration cycle, GAP_CYCLES=1), continuous back-to-back.
- ser_din=0 and src_rd=0 outside DATA. ser_din_valid is high only in START.
- Request drop after grant is ignored; the frame always completes.
- enable deasserted mid-frame: the current frame completes; no new grant while low.
- Simultaneous requests: exactly one grant. A source re-requesting immediately after its frame yields to other pending requesters.
- Single requester: it is re-granted every frame period.
- Reset mid-frame: immediate return to reset values. The serializer resets on the same rst, so no partial-frame recovery is needed.
- DATA counter width $clog2(NUM_CHANNELS). It wraps to 0 on exit and never exceeds NUM_CHANNELS-1.

Decomposition:
- Shared package (serializer_pkg):
  - state encoding constants
  - HEADER 8'hAA, FOOTER 8'hFF
  - NUM_CHANNELS default 16
  - sample width 8
- Sub-module rr_arbiter (NUM_SRC): combinational one-hot pick from req and pointer. Reusable elsewhere.
- Top holds the FSM, counters and data mux.

Test Plan:
1. Reset then src_req=4'b0001 held, src_data[0] counting 0x00..0x0F -> serializer dout shows AA, 00..0F, FF. src_rd[0] high exactly 16 cycles. ser_din_valid a single pulse 2 cycles before the first data word.
2. src_req=4'b1111 constant -> grants in order 0,1,2,3,0. Frame starts (ser_din_valid) spaced exactly 21 cycles apart at GAP_CYCLES=1.
3. src_req[2] pulsed 1 cycle in IDLE then dropped -> full 16-word frame from source 2, frame_src=2, frame_done pulse in footer cycle.
4. enable dropped at the 5th DATA cycle with requests pending -> frame finishes (16 reads, footer). No further ser_din_valid until enable=1.
5. rst asserted at DATA counter=7 -> next cycle all outputs 0, busy=0. After release with src_req=4'b0010, a clean frame from source 1.
6. Single source 3 requesting continuously -> back-to-back frames from source 3 with no gaps beyond GAP_CYCLES. Never two grant bits set.
